// File: rtl/regfile_write_arbiter_if.sv
// Write-side bundle between the host/physics requesters and the register-file write arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              avl_wr_valid;
    logic [ADDR_W-1:0] avl_wr_addr;
    logic [31:0]       avl_wr_data;
    logic [3:0]        avl_wr_be;
    logic              avl_wr_ready;

    logic [1:0]        fsm_we;
    logic [ADDR_W-1:0] fsm_addr1, fsm_addr2, fsm_addr3, fsm_addr4, fsm_addr5, fsm_addr6;
    logic [31:0]       fsm_data1, fsm_data2, fsm_data3, fsm_data4, fsm_data5, fsm_data6;
    logic              fsm_clear;
    logic              fsm_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [31:0]       rf_data;
    logic [3:0]        rf_be;

    modport slave (
        input  avl_wr_valid, avl_wr_addr, avl_wr_data, avl_wr_be,
        output avl_wr_ready,
        input  fsm_we,
        input  fsm_addr1, fsm_addr2, fsm_addr3, fsm_addr4, fsm_addr5, fsm_addr6,
        input  fsm_data1, fsm_data2, fsm_data3, fsm_data4, fsm_data5, fsm_data6,
        input  fsm_clear,
        output fsm_ready,
        output rf_we, rf_addr, rf_data, rf_be
    );

    modport master (
        output avl_wr_valid, avl_wr_addr, avl_wr_data, avl_wr_be,
        input  avl_wr_ready,
        output fsm_we,
        output fsm_addr1, fsm_addr2, fsm_addr3, fsm_addr4, fsm_addr5, fsm_addr6,
        output fsm_data1, fsm_data2, fsm_data3, fsm_data4, fsm_data5, fsm_data6,
        output fsm_clear,
        input  fsm_ready,
        input  rf_we, rf_addr, rf_data, rf_be
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared between the Avalon host and the physics FSM
// (buffered 6-slot bursts and acceleration-word clearing).
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned RF_SIZE  = 113,
    parameter int unsigned ACC_BASE = 83,
    parameter int unsigned ACC_LEN  = 30
) (
    input  logic                     CLK,
    input  logic                     RESET,
    regfile_write_arbiter_if.slave   bus,
    output logic                     busy,
    output logic                     addr_err
);
    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    localparam logic [ADDR_W:0]   RF_LIMIT  = (ADDR_W+1)'(RF_SIZE);
    localparam logic [ADDR_W-1:0] ACC_FIRST = ADDR_W'(ACC_BASE);
    localparam logic [ADDR_W-1:0] ACC_LAST  = ADDR_W'(ACC_BASE + ACC_LEN - 1);

    state_t            state_q, state_d;
    logic [5:0]        mask_q, mask_d;
    logic              pend_clear_q, pend_clear_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_fsm_q, last_fsm_d;

    logic [ADDR_W-1:0] slot_addr_q [6];
    logic [31:0]       slot_data_q [6];
    logic [ADDR_W-1:0] in_addr [6];
    logic [31:0]       in_data [6];
    logic              load_slots;

    logic [2:0]        slot_idx;
    logic              slot_found;
    logic              fsm_pend, avl_grant, fsm_grant, accept;
    logic [5:0]        burst_sel;

    logic              wr_en, wr_bad;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    always_comb begin
        in_addr = '{bus.fsm_addr1, bus.fsm_addr2, bus.fsm_addr3,
                    bus.fsm_addr4, bus.fsm_addr5, bus.fsm_addr6};
        in_data = '{bus.fsm_data1, bus.fsm_data2, bus.fsm_data3,
                    bus.fsm_data4, bus.fsm_data5, bus.fsm_data6};
    end

    always_comb begin
        slot_idx   = '0;
        slot_found = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (mask_q[i] && !slot_found) begin
                slot_idx   = 3'(i);
                slot_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (bus.fsm_we)
            2'd1:    burst_sel = 6'b000111;
            2'd2:    burst_sel = 6'b111000;
            2'd3:    burst_sel = 6'b111111;
            default: burst_sel = 6'b000000;
        endcase
    end

    // Alternation: whoever was granted last yields when both sides contend.
    always_comb begin
        fsm_pend  = (state_q != IDLE);
        avl_grant = !RESET && bus.avl_wr_valid && (!fsm_pend || last_fsm_q);
        fsm_grant = !RESET && fsm_pend && (!bus.avl_wr_valid || !last_fsm_q);
        bus.avl_wr_ready = avl_grant;
        bus.fsm_ready    = !RESET && (state_q == IDLE) && (mask_q == '0);
        busy             = !RESET && ((state_q != IDLE) || pend_clear_q);
        accept = bus.fsm_ready && ((bus.fsm_we != 2'd0) || bus.fsm_clear);
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        pend_clear_d = pend_clear_q;
        cnt_d        = cnt_q;
        last_fsm_d   = last_fsm_q;
        load_slots   = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = bus.avl_wr_addr;
        wr_data      = bus.avl_wr_data;
        wr_be        = bus.avl_wr_be;

        if (avl_grant) begin
            wr_en      = 1'b1;
            last_fsm_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.fsm_we != 2'd0) begin
                        load_slots   = 1'b1;
                        mask_d       = burst_sel;
                        pend_clear_d = bus.fsm_clear;
                        state_d      = DRAIN;
                    end else begin
                        cnt_d   = ACC_FIRST;
                        state_d = CLEAR;
                    end
                end
            end
            DRAIN: begin
                if (fsm_grant) begin
                    wr_en      = 1'b1;
                    wr_addr    = slot_addr_q[slot_idx];
                    wr_data    = slot_data_q[slot_idx];
                    wr_be      = 4'hF;
                    last_fsm_d = 1'b1;
                    mask_d     = mask_q & ~(6'b000001 << slot_idx);
                    if (mask_d == '0) begin
                        if (pend_clear_q) begin
                            pend_clear_d = 1'b0;
                            cnt_d        = ACC_FIRST;
                            state_d      = CLEAR;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            CLEAR: begin
                if (fsm_grant) begin
                    wr_en      = 1'b1;
                    wr_addr    = cnt_q;
                    wr_data    = '0;
                    wr_be      = 4'hF;
                    last_fsm_d = 1'b1;
                    if (cnt_q == ACC_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_bad = wr_en && ({1'b0, wr_addr} >= RF_LIMIT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            pend_clear_q <= 1'b0;
            cnt_q        <= ACC_FIRST;
            last_fsm_q   <= 1'b1;
            bus.rf_we    <= 1'b0;
            bus.rf_addr  <= '0;
            bus.rf_data  <= '0;
            bus.rf_be    <= '0;
            addr_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pend_clear_q <= pend_clear_d;
            cnt_q        <= cnt_d;
            last_fsm_q   <= last_fsm_d;
            bus.rf_we    <= wr_en && !wr_bad;
            addr_err     <= wr_bad;
            if (wr_en && !wr_bad) begin
                bus.rf_addr <= wr_addr;
                bus.rf_data <= wr_data;
                bus.rf_be   <= wr_be;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (load_slots) begin
            for (int unsigned i = 0; i < 6; i++) begin
                slot_addr_q[i] <= in_addr[i];
                slot_data_q[i] <= in_data[i];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
    logic clk;
    logic reset;
    logic busy;
    logic addr_err;
    int   n_checks;
    int   n_fail;

    regfile_write_arbiter_if #(.ADDR_W(7)) bus ();

    regfile_write_arbiter #(
        .ADDR_W  (7),
        .RF_SIZE (113),
        .ACC_BASE(83),
        .ACC_LEN (30)
    ) dut (
        .CLK     (clk),
        .RESET   (reset),
        .bus     (bus),
        .busy    (busy),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.avl_wr_valid = 1'b0;
        bus.avl_wr_addr  = '0;
        bus.avl_wr_data  = '0;
        bus.avl_wr_be    = '0;
        bus.fsm_we       = 2'd0;
        bus.fsm_clear    = 1'b0;
    endtask

    task automatic set_slot(input int idx, input logic [6:0] a, input logic [31:0] d);
        case (idx)
            1: begin bus.fsm_addr1 = a; bus.fsm_data1 = d; end
            2: begin bus.fsm_addr2 = a; bus.fsm_data2 = d; end
            3: begin bus.fsm_addr3 = a; bus.fsm_data3 = d; end
            4: begin bus.fsm_addr4 = a; bus.fsm_data4 = d; end
            5: begin bus.fsm_addr5 = a; bus.fsm_data5 = d; end
            default: begin bus.fsm_addr6 = a; bus.fsm_data6 = d; end
        endcase
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [6:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        check({tag, "_we"}, 32'(bus.rf_we), 32'(we));
        check({tag, "_addr"}, 32'(bus.rf_addr), 32'(a));
        check({tag, "_data"}, bus.rf_data, d);
        check({tag, "_be"}, 32'(bus.rf_be), 32'(be));
    endtask

    initial begin
        logic [6:0]  alt_addr [6];
        logic [31:0] alt_data [6];
        int          busy_drops;
        int          extra_we;

        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        for (int i = 1; i <= 6; i++) set_slot(i, '0, '0);

        // Reset with every request asserted: nothing may be granted or written.
        reset = 1'b1;
        bus.avl_wr_valid = 1'b1;
        bus.avl_wr_addr  = 7'd3;
        bus.fsm_we       = 2'd3;
        bus.fsm_clear    = 1'b1;
        tick();
        tick();
        check_rf("rst", 1'b0, 7'd0, 32'd0, 4'h0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_avl_rdy", 32'(bus.avl_wr_ready), 32'd0);
        check("rst_fsm_rdy", 32'(bus.fsm_ready), 32'd0);
        idle_inputs();
        reset = 1'b0;
        tick();

        // Full six-slot burst, no Avalon traffic.
        bus.fsm_we = 2'd3;
        for (int i = 1; i <= 6; i++) set_slot(i, 7'(23 + i), 32'(i));
        #1;
        check("b6_fsm_rdy", 32'(bus.fsm_ready), 32'd1);
        tick();
        bus.fsm_we = 2'd0;
        #1;
        check("b6_busy", 32'(busy), 32'd1);
        check("b6_fsm_rdy_lo", 32'(bus.fsm_ready), 32'd0);
        check("b6_no_early_we", 32'(bus.rf_we), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_rf("b6_slot", 1'b1, 7'(24 + i), 32'(i + 1), 4'hF);
        end
        tick();
        check("b6_done_we", 32'(bus.rf_we), 32'd0);
        check("b6_done_busy", 32'(busy), 32'd0);

        // Avalon: normal write, out-of-range drop, zero byte enables.
        bus.avl_wr_valid = 1'b1;
        bus.avl_wr_addr  = 7'd5;
        bus.avl_wr_data  = 32'h1234_5678;
        bus.avl_wr_be    = 4'b0101;
        #1;
        check("avl_rdy", 32'(bus.avl_wr_ready), 32'd1);
        tick();
        check_rf("avl_wr", 1'b1, 7'd5, 32'h1234_5678, 4'b0101);
        bus.avl_wr_addr = 7'd113;
        bus.avl_wr_data = 32'hFFFF_FFFF;
        bus.avl_wr_be   = 4'hF;
        #1;
        check("avl_bad_rdy", 32'(bus.avl_wr_ready), 32'd1);
        tick();
        check("avl_bad_we", 32'(bus.rf_we), 32'd0);
        check("avl_bad_err", 32'(addr_err), 32'd1);
        bus.avl_wr_addr = 7'd7;
        bus.avl_wr_data = 32'hCAFE_0007;
        bus.avl_wr_be   = 4'h0;
        tick();
        check_rf("avl_be0", 1'b1, 7'd7, 32'hCAFE_0007, 4'h0);
        check("avl_err_pulse", 32'(addr_err), 32'd0);
        idle_inputs();
        tick();

        // Clear alone: 30 zero writes over the acceleration words.
        bus.fsm_clear = 1'b1;
        #1;
        check("clr_fsm_rdy", 32'(bus.fsm_ready), 32'd1);
        tick();
        bus.fsm_clear = 1'b0;
        #1;
        check("clr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            check_rf("clr", 1'b1, 7'(83 + i), 32'd0, 4'hF);
        end
        tick();
        check("clr_end_we", 32'(bus.rf_we), 32'd0);
        check("clr_end_rdy", 32'(bus.fsm_ready), 32'd1);
        check("clr_end_busy", 32'(busy), 32'd0);

        // Burst on slots 4-6 plus clear: slots first, then zeroing, busy throughout.
        for (int i = 1; i <= 3; i++) set_slot(i, 7'd10, 32'hDEAD_0000);
        set_slot(4, 7'd40, 32'h44);
        set_slot(5, 7'd41, 32'h55);
        set_slot(6, 7'd42, 32'h66);
        bus.fsm_we    = 2'd2;
        bus.fsm_clear = 1'b1;
        tick();
        idle_inputs();
        busy_drops = 0;
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1) busy_drops++;
            tick();
            if (i < 3)
                check_rf("bc_slot", 1'b1, 7'(40 + i), 32'h44 + 32'(i) * 32'h11, 4'hF);
            else
                check_rf("bc_clr", 1'b1, 7'(83 + i - 3), 32'd0, 4'hF);
        end
        check("bc_busy_drops", 32'(busy_drops), 32'd0);
        tick();
        check("bc_end_we", 32'(bus.rf_we), 32'd0);
        check("bc_end_busy", 32'(busy), 32'd0);

        // Duplicate addresses written in slot order; out-of-range slot dropped.
        set_slot(1, 7'd50, 32'd1);
        set_slot(2, 7'd50, 32'd2);
        set_slot(3, 7'd120, 32'd3);
        bus.fsm_we = 2'd1;
        tick();
        bus.fsm_we = 2'd0;
        tick();
        check_rf("dup1", 1'b1, 7'd50, 32'd1, 4'hF);
        tick();
        check_rf("dup2", 1'b1, 7'd50, 32'd2, 4'hF);
        tick();
        check("slot_bad_we", 32'(bus.rf_we), 32'd0);
        check("slot_bad_err", 32'(addr_err), 32'd1);
        tick();
        check("slot_err_pulse", 32'(addr_err), 32'd0);

        // Contention straight after reset: Avalon first, then strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_slot(1, 7'd60, 32'h10);
        set_slot(2, 7'd61, 32'h20);
        set_slot(3, 7'd62, 32'h30);
        bus.fsm_we = 2'd1;
        tick();
        bus.fsm_we       = 2'd0;
        bus.avl_wr_valid = 1'b1;
        bus.avl_wr_addr  = 7'd1;
        bus.avl_wr_data  = 32'hA5;
        bus.avl_wr_be    = 4'hF;
        alt_addr = '{7'd1, 7'd60, 7'd1, 7'd61, 7'd1, 7'd62};
        alt_data = '{32'hA5, 32'h10, 32'hA5, 32'h20, 32'hA5, 32'h30};
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_rdy", 32'(bus.avl_wr_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            check_rf("alt", 1'b1, alt_addr[i], alt_data[i], 4'hF);
        end
        idle_inputs();
        tick();

        // Reset after two burst writes discards the rest.
        for (int i = 1; i <= 6; i++) set_slot(i, 7'(69 + i), 32'(6 + i));
        bus.fsm_we = 2'd3;
        tick();
        bus.fsm_we = 2'd0;
        tick();
        check_rf("rb_w1", 1'b1, 7'd70, 32'd7, 4'hF);
        tick();
        check_rf("rb_w2", 1'b1, 7'd71, 32'd8, 4'hF);
        reset = 1'b1;
        #1;
        check("rb_rst_busy", 32'(busy), 32'd0);
        check("rb_rst_rdy", 32'(bus.fsm_ready), 32'd0);
        tick();
        check("rb_rst_we", 32'(bus.rf_we), 32'd0);
        reset = 1'b0;
        #1;
        check("rb_post_rdy", 32'(bus.fsm_ready), 32'd1);
        check("rb_post_busy", 32'(busy), 32'd0);
        extra_we = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rf_we !== 1'b0) extra_we++;
        end
        check("rb_no_more_we", 32'(extra_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register-file address width.
REQ-002 SHALL have parameter RF_SIZE, default 113, number of valid register-file words.
REQ-003 SHALL have parameter ACC_BASE, default 83, first acceleration word; ACC_LEN, default 30, acceleration words to clear.
REQ-004 SHALL have port CLK  input  1  clock.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports avl_wr_valid / avl_wr_addr / avl_wr_data / avl_wr_be  input  1 / ADDR_W / 32 / 4  host write request.
REQ-007 SHALL have port avl_wr_ready  output  1  host write accepted this cycle.
REQ-008 SHALL have port fsm_we  input  2  burst select: 0 none, 1 slots 1-3, 2 slots 4-6, 3 slots 1-6.
REQ-009 SHALL have ports fsm_addr1..fsm_addr6 / fsm_data1..fsm_data6  input  ADDR_W / 32  physics write burst.
REQ-010 SHALL have port fsm_clear  input  1  request zeroing of acceleration words.
REQ-011 SHALL have port fsm_ready  output  1  burst/clear request accepted this cycle.
REQ-012 SHALL have ports rf_we / rf_addr / rf_data / rf_be  output  1 / ADDR_W / 32 / 4  single register-file write port, registered.
REQ-013 SHALL have ports busy  output  1  (FSM buffer non-empty or clear active); addr_err  output  1  one-cycle drop pulse.

Function
REQ-014 SHALL own the only register-file write port; one write issued per cycle maximum.
REQ-015 SHALL implement states IDLE, DRAIN (buffered FSM slots pending), CLEAR (acceleration zeroing).
REQ-016 fsm_ready SHALL be 1 only in IDLE with empty buffer; a request is accepted on fsm_ready & (fsm_we!=0 | fsm_clear).
REQ-017 On accepted fsm_we!=0: latch selected slots (addr, data) and 6-bit valid mask, go to DRAIN.
REQ-018 On accepted fsm_clear with fsm_we==0: load counter ACC_BASE, go to CLEAR.
REQ-019 fsm_clear and fsm_we!=0 accepted together: burst latched first; CLEAR entered after DRAIN empties (pending-clear flag).
REQ-020 DRAIN SHALL issue slots in ascending index, lowest valid slot first, clearing its mask bit; rf_be=4'hF.
REQ-021 CLEAR SHALL issue rf_data=0, rf_be=4'hF at counter, counter+1, through ACC_BASE+ACC_LEN-1, then IDLE.
REQ-022 Arbitration, both Avalon valid and FSM word pending: alternate grants with last-grant bit; Avalon wins first after reset.
REQ-023 Single requester pending: granted every cycle.
REQ-024 avl_wr_ready SHALL be combinational, asserted in the cycle Avalon is granted; in IDLE with nothing buffered Avalon always granted.
REQ-025 Latency: granted request appears on rf_* exactly 1 cycle after grant; FSM burst accepted in cycle N issues its first slot no earlier than N+1.
REQ-026 Address >= RF_SIZE (either source): consume request, rf_we=0 that cycle, addr_err=1 for one cycle.
REQ-027 Duplicate addresses in a burst SHALL be written in slot order (last slot wins).
REQ-028 Avalon byte enables SHALL pass unchanged; avl_wr_be==0 issues rf_we=1 with rf_be=0.
REQ-029 busy SHALL be 1 in DRAIN, CLEAR, or with pending-clear flag set.

Reset
REQ-030 RESET SHALL force IDLE, empty mask, pending-clear 0, last-grant=FSM (so Avalon wins first), counter ACC_BASE.
REQ-031 During/next cycle after RESET: rf_we=0, rf_addr=0, rf_data=0, rf_be=0, addr_err=0, busy=0, avl_wr_ready=0, fsm_ready=0.
REQ-032 RESET mid-DRAIN or mid-CLEAR SHALL discard remaining work; no further rf_we until new requests.

Verification
REQ-033 fsm_we=3, addrs 24..29, data 1..6, no Avalon -> rf_we 6 consecutive cycles from N+1, addrs 24..29 in order, data 1..6, rf_be=F.
REQ-034 fsm_we=1 burst pending + avl_wr_valid held addr 1 data 0xA5 -> rf sequence Avalon, FSM, Avalon, FSM, ... alternating; avl_wr_ready on Avalon cycles only.
REQ-035 fsm_clear alone -> 30 writes, addrs 83..112, data 0, then fsm_ready=1 and busy=0 next cycle.
REQ-036 Avalon write addr 113 data 0xFFFFFFFF -> avl_wr_ready=1, rf_we=0, addr_err=1 one cycle.
REQ-037 fsm_we=2 + fsm_clear same cycle -> 3 slot writes then 30 zero writes, busy=1 throughout.
REQ-038 RESET asserted after 2 of 6 burst writes -> no further rf_we; fsm_ready=1 first cycle after RESET deasserts.
